// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: default widths, the IF/ID bubble word,
// base opcodes and the fetch FSM state encoding.
package rv_pipe_pkg;

  localparam int          DEFAULT_XLEN = 32;
  localparam logic [31:0] BUBBLE_WORD  = 32'h0000_0000;

  // ID treats opcode 0 as a bubble, so a cleared IF/ID register is harmless.
  localparam logic [6:0] OPC_BUBBLE = 7'b0000000;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_hold_buffer.sv
// One-entry skid buffer holding a returned instruction while ID is stalled.
// Clear wins over load, load wins over consume.
module if_hold_buffer
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_consume,
  input  logic            i_clear,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic            o_valid
);

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= BUBBLE_WORD;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage plus IF/ID register: single-outstanding imem port,
// stall/flush handling from ID and branch redirects from ID/EX.
module if_fetch_unit
  import rv_pipe_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     BUBBLE   = BUBBLE_WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            ifid_write,
  input  logic            if_flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ifid_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic            ifid_valid
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_stale;
  logic [31:0]     r_ifid_instr;
  logic [XLEN-1:0] r_ifid_pc;
  logic            r_ifid_valid;

  logic            w_req;
  logic            w_accept;
  logic            w_resp;
  logic            w_resp_live;
  logic            w_buf_load;
  logic            w_buf_consume;
  logic [31:0]     w_buf_instr;
  logic [XLEN-1:0] w_buf_pc;
  logic            w_buf_valid;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_req         = rst_n && (r_state == ST_FETCH) && pc_write;
  assign w_accept      = w_req && imem_ready;
  assign w_resp        = (r_state == ST_WAIT) && imem_rvalid;
  // A response is only usable if it belongs to the current path.
  assign w_resp_live   = w_resp && !r_stale && !redirect_valid;
  assign w_buf_load    = w_resp_live && !ifid_write;
  assign w_buf_consume = w_buf_valid && ifid_write;
  assign w_redirect_pc = redirect_pc & ALIGN_MASK;

  if_hold_buffer #(.XLEN(XLEN)) u_hold_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_buf_load),
    .i_instr  (imem_rdata),
    .i_pc     (r_req_pc),
    .i_consume(w_buf_consume),
    .i_clear  (redirect_valid),
    .o_instr  (w_buf_instr),
    .o_pc     (w_buf_pc),
    .o_valid  (w_buf_valid)
  );

  // Redirect overrides everything; a request still in flight afterwards is
  // marked stale so its response is dropped when it eventually returns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_stale  <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_pc;
      if (w_accept || ((r_state == ST_WAIT) && !imem_rvalid)) begin
        r_stale <= 1'b1;
        r_state <= ST_WAIT;
      end else begin
        r_stale <= 1'b0;
        r_state <= ST_FETCH;
      end
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (w_accept) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + PC_STEP;
            r_stale  <= 1'b0;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            r_stale <= 1'b0;
            r_state <= (r_stale || ifid_write) ? ST_FETCH : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ifid_write) r_state <= ST_FETCH;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The buffer and a live response never coexist, so their order is moot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ifid_instr <= BUBBLE;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
    end else if (ifid_write) begin
      if (if_flush || redirect_valid) begin
        r_ifid_instr <= BUBBLE;
        r_ifid_pc    <= '0;
        r_ifid_valid <= 1'b0;
      end else if (w_buf_valid) begin
        r_ifid_instr <= w_buf_instr;
        r_ifid_pc    <= w_buf_pc;
        r_ifid_valid <= 1'b1;
      end else if (w_resp_live) begin
        r_ifid_instr <= imem_rdata;
        r_ifid_pc    <= r_req_pc;
        r_ifid_valid <= 1'b1;
      end else begin
        r_ifid_instr <= BUBBLE;
        r_ifid_pc    <= '0;
        r_ifid_valid <= 1'b0;
      end
    end
  end

  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a flag-level fetch model.
module tb_if_fetch_unit;

  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        ifid_write;
  logic        if_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;

  always #5 clk = ~clk;

  if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .BUBBLE(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .if_flush      (if_flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_valid    (ifid_valid)
  );

  int totalChecks = 0;
  int passChecks  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual === expected) passChecks++;
    else $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00a0_0113;
      32'h8:   return 32'h0020_8233;
      default: return (a ^ 32'h5A5A_0000) | 32'h0000_0003;
    endcase
  endfunction

  function automatic logic [31:0] qAt(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int countIn(input logic [31:0] q[$], input logic [31:0] v);
    int c = 0;
    foreach (q[i]) if (q[i] == v) c++;
    return c;
  endfunction

  // Instruction memory: accepts one request, answers memLat cycles later.
  int          memLat = 1;
  bit          memBusy = 1'b0;
  int          memCnt = 0;
  logic [31:0] memAddr = '0;
  bit          sAcc = 1'b0;
  logic [31:0] sAddr = '0;

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  end

  always @(posedge clk) begin
    if (imem_rvalid) memBusy = 1'b0;
    if (sAcc) begin
      memBusy = 1'b1;
      memAddr = sAddr;
      memCnt  = memLat - 1;
    end else if (memBusy && memCnt > 0) begin
      memCnt--;
    end
    #1;
    imem_rvalid = memBusy && (memCnt == 0);
    imem_rdata  = imem_rvalid ? memWord(memAddr) : $urandom;
  end

  // Transaction logs for the directed scenarios.
  logic [31:0] acceptLog[$];
  logic [31:0] ifidPcLog[$];
  logic [31:0] ifidInstrLog[$];
  bit          loadedEdge = 1'b0;

  always @(posedge clk) loadedEdge = rst_n && ifid_write;

  always @(negedge clk) begin
    sAcc  = imem_req && imem_ready;
    sAddr = imem_addr;
    if (rst_n && sAcc) acceptLog.push_back(imem_addr);
    if (loadedEdge && ifid_valid) begin
      ifidPcLog.push_back(ifid_pc);
      ifidInstrLog.push_back(ifid_instr);
    end
  end

  // Reference model in terms of "started / outstanding / stale / buffered".
  bit          mInit = 1'b0;
  bit          mStarted, mOut, mStale, mBuf, mIfidValid;
  logic [31:0] mPc, mReqAddr, mBufInstr, mBufPc, mIfidInstr, mIfidPc;
  bit          acc, resp, live;

  always @(posedge clk) begin
    if (!rst_n) begin
      mInit = 1'b1;
      mStarted = 1'b0; mOut = 1'b0; mStale = 1'b0; mBuf = 1'b0;
      mPc = 32'h0; mReqAddr = 32'h0;
      mIfidInstr = BUBBLE; mIfidPc = 32'h0; mIfidValid = 1'b0;
    end else begin
      acc  = mStarted && pc_write && !mOut && !mBuf && imem_ready;
      resp = mOut && imem_rvalid;
      live = resp && !mStale && !redirect_valid;
      if (ifid_write) begin
        if (if_flush || redirect_valid) begin
          mIfidInstr = BUBBLE; mIfidValid = 1'b0;
        end else if (mBuf) begin
          mIfidInstr = mBufInstr; mIfidPc = mBufPc; mIfidValid = 1'b1;
        end else if (live) begin
          mIfidInstr = imem_rdata; mIfidPc = mReqAddr; mIfidValid = 1'b1;
        end else begin
          mIfidInstr = BUBBLE; mIfidValid = 1'b0;
        end
      end
      if (redirect_valid) begin
        mStarted = 1'b1;
        mBuf     = 1'b0;
        mOut     = acc || (mOut && !resp);
        mStale   = mOut;
        mPc      = redirect_pc & 32'hFFFF_FFFC;
      end else if (!mStarted) begin
        mStarted = 1'b1;
      end else begin
        if (mBuf && ifid_write) mBuf = 1'b0;
        if (acc) begin
          mReqAddr = mPc; mPc = mPc + 32'd4; mOut = 1'b1; mStale = 1'b0;
        end
        if (resp) begin
          mOut = 1'b0;
          if (!mStale && !ifid_write) begin
            mBuf = 1'b1; mBufInstr = imem_rdata; mBufPc = mReqAddr;
          end
          mStale = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mInit) begin
      checkOutput("imem_req", imem_req, rst_n && mStarted && pc_write && !mOut && !mBuf);
      checkOutput("imem_addr", imem_addr, mPc);
      checkOutput("ifid_valid", ifid_valid, mIfidValid);
      checkOutput("ifid_instr", ifid_instr, mIfidInstr);
      if (mIfidValid) checkOutput("ifid_pc", ifid_pc, mIfidPc);
    end
  end

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit pw, input bit iw, input bit fl, input bit rv,
                               input logic [31:0] rpc, input bit rdy);
    pc_write       = pw;
    ifid_write     = iw;
    if_flush       = fl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ready     = rdy;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1, 1, 0, 0, 32'h0, 1);
    repeat (4) waitCycle();
    acceptLog.delete();
    ifidPcLog.delete();
    ifidInstrLog.delete();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    applyStimulus(1, 1, 0, 0, 32'h0, 1);

    // Reset values and the first two back-to-back fetches.
    doReset();
    checkOutput("rst_ifid_valid", ifid_valid, 0);
    checkOutput("rst_ifid_instr", ifid_instr, BUBBLE);
    checkOutput("rst_ifid_pc", ifid_pc, 0);
    checkOutput("rst_imem_req", imem_req, 0);
    checkOutput("rst_imem_addr", imem_addr, 0);
    rst_n = 1'b1;
    n = 0;
    while (ifidPcLog.size() < 2 && n < 20) begin waitCycle(); n++; end
    checkOutput("t1_timeout", n >= 20, 0);
    checkOutput("t1_acc0", qAt(acceptLog, 0), 32'h0);
    checkOutput("t1_acc1", qAt(acceptLog, 1), 32'h4);
    checkOutput("t1_acc2", qAt(acceptLog, 2), 32'h8);
    checkOutput("t1_ifid0_pc", qAt(ifidPcLog, 0), 32'h0);
    checkOutput("t1_ifid0_instr", qAt(ifidInstrLog, 0), 32'h0050_0093);
    checkOutput("t1_ifid1_pc", qAt(ifidPcLog, 1), 32'h4);
    checkOutput("t1_ifid1_instr", qAt(ifidInstrLog, 1), 32'h00a0_0113);

    // Stall while the response for 0x8 arrives: it must wait in the buffer.
    applyStimulus(1, 0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t2_frozen_valid", ifid_valid, 0);
      checkOutput("t2_frozen_instr", ifid_instr, BUBBLE);
      waitCycle();
    end
    checkOutput("t2_no_fetch_in_hold", acceptLog.size(), 3);
    applyStimulus(1, 1, 0, 0, 32'h0, 1);
    n = 0;
    while (ifidPcLog.size() < 3 && n < 10) begin waitCycle(); n++; end
    checkOutput("t2_timeout", n >= 10, 0);
    checkOutput("t2_ifid_pc", qAt(ifidPcLog, 2), 32'h8);
    checkOutput("t2_ifid_instr", qAt(ifidInstrLog, 2), 32'h0020_8233);
    repeat (6) waitCycle();
    checkOutput("t2_no_dup", countIn(ifidPcLog, 32'h8), 1);

    // Redirect to 0x103 while the fetch of 0x8 is still outstanding.
    doReset();
    memLat = 3;
    rst_n = 1'b1;
    n = 0;
    while (acceptLog.size() < 3 && n < 40) begin waitCycle(); n++; end
    checkOutput("t3_timeout_a", n >= 40, 0);
    applyStimulus(1, 1, 0, 1, 32'h0000_0103, 1);
    waitCycle();
    applyStimulus(1, 1, 0, 0, 32'h0, 1);
    n = 0;
    while (ifidPcLog.size() < 3 && n < 30) begin waitCycle(); n++; end
    checkOutput("t3_timeout_b", n >= 30, 0);
    checkOutput("t3_next_fetch", qAt(acceptLog, 3), 32'h100);
    checkOutput("t3_ifid_pc", qAt(ifidPcLog, 2), 32'h100);
    checkOutput("t3_ifid_instr", qAt(ifidInstrLog, 2), memWord(32'h100));
    checkOutput("t3_no_pc8", countIn(ifidPcLog, 32'h8), 0);

    // Redirect to 0x40 in the very cycle the fetch of 0xC is accepted.
    doReset();
    memLat = 1;
    rst_n = 1'b1;
    n = 0;
    while (!(imem_req && imem_addr == 32'hC) && n < 30) begin waitCycle(); n++; end
    checkOutput("t4_timeout_a", n >= 30, 0);
    applyStimulus(1, 1, 0, 1, 32'h0000_0040, 1);
    waitCycle();
    applyStimulus(1, 1, 0, 0, 32'h0, 1);
    n = 0;
    while (ifidPcLog.size() < 4 && n < 20) begin waitCycle(); n++; end
    checkOutput("t4_timeout_b", n >= 20, 0);
    checkOutput("t4_next_fetch", qAt(acceptLog, 4), 32'h40);
    checkOutput("t4_no_fetch_10", countIn(acceptLog, 32'h10), 0);
    checkOutput("t4_ifid_pc", qAt(ifidPcLog, 3), 32'h40);
    checkOutput("t4_no_pcC", countIn(ifidPcLog, 32'hC), 0);

    // Flush while an instruction sits in the buffer.
    doReset();
    memLat = 1;
    applyStimulus(1, 0, 0, 0, 32'h0, 1);
    rst_n = 1'b1;
    repeat (5) waitCycle();
    checkOutput("t5_hold_req", imem_req, 0);
    checkOutput("t5_hold_addr", imem_addr, 32'h4);
    applyStimulus(1, 1, 1, 0, 32'h0, 1);
    waitCycle();
    checkOutput("t5_flush_valid", ifid_valid, 0);
    checkOutput("t5_flush_instr", ifid_instr, BUBBLE);
    checkOutput("t5_flush_addr", imem_addr, 32'h4);
    applyStimulus(1, 1, 0, 0, 32'h0, 1);
    n = 0;
    while (ifidPcLog.size() < 1 && n < 20) begin waitCycle(); n++; end
    checkOutput("t5_timeout", n >= 20, 0);
    checkOutput("t5_refetch", qAt(acceptLog, 1), 32'h4);
    checkOutput("t5_first_ifid_pc", qAt(ifidPcLog, 0), 32'h4);

    // Reset in WAIT with the response landing during reset.
    doReset();
    memLat = 3;
    rst_n = 1'b1;
    n = 0;
    while (acceptLog.size() < 2 && n < 30) begin waitCycle(); n++; end
    checkOutput("t6_timeout_a", n >= 30, 0);
    rst_n = 1'b0;
    repeat (4) waitCycle();
    checkOutput("t6_rst_req", imem_req, 0);
    checkOutput("t6_rst_valid", ifid_valid, 0);
    acceptLog.delete();
    ifidPcLog.delete();
    ifidInstrLog.delete();
    rst_n = 1'b1;
    checkOutput("t6_rel_instr", ifid_instr, BUBBLE);
    n = 0;
    while (ifidPcLog.size() < 1 && n < 30) begin waitCycle(); n++; end
    checkOutput("t6_timeout_b", n >= 30, 0);
    checkOutput("t6_first_fetch", qAt(acceptLog, 0), 32'h0);
    checkOutput("t6_first_ifid_pc", qAt(ifidPcLog, 0), 32'h0);
    checkOutput("t6_first_ifid_instr", qAt(ifidInstrLog, 0), 32'h0050_0093);

    // Randomized traffic; the per-cycle compare does the checking.
    doReset();
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      memLat = $urandom_range(1, 3);
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
                    $urandom, $urandom_range(0, 3) != 0);
      waitCycle();
    end
    applyStimulus(1, 1, 0, 0, 32'h0, 1);
    repeat (8) waitCycle();

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
